branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 1024, pattern-history-table depth; power of two, 16..4096.
REQ-002 SHALL have parameter BTB_ENTRIES, default 256, direct-mapped branch-target-buffer depth; power of two, 16..1024.
REQ-003 SHALL have parameter GHR_BITS, default 10, global-history length; 1..log2(BHT_ENTRIES).
REQ-004 SHALL have parameter CTR_BITS, default 2, saturating-counter width; 2..4.
REQ-005 SHALL have port i_clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_IF_pc  input  32  fetch PC.
REQ-008 SHALL have port i_IF_valid  input  1  fetch advances this cycle (not stalled).
REQ-009 SHALL have port o_IF_pred_taken  output  1  fetch PC predicted taken.
REQ-010 SHALL have port o_IF_pc_target  output  32  next fetch PC.
REQ-011 SHALL have port o_IF_ghr  output  GHR_BITS  history snapshot used for this fetch; travels down pipe with the instruction.
REQ-012 SHALL have ports i_EX_valid (1, control-flow instruction resolving in EX), i_EX_pc (32), i_EX_pc_sel (1, actual taken), i_EX_alu_data (32, actual target), all inputs.
REQ-013 SHALL have inputs i_EX_pred_taken (1), i_EX_pred_target (32), i_EX_ghr (GHR_BITS): prediction info carried from IF.
REQ-014 SHALL have port o_branch_flush  output  1  misprediction, flush IF/ID.
REQ-015 SHALL have ports o_perf_branches and o_perf_mispred  output  32  event counters.

Function
REQ-016 SHALL index PHT with i_IF_pc[log2(BHT_ENTRIES)+1:2] XOR zero-extended GHR; EX side uses i_EX_pc and i_EX_ghr likewise.
REQ-017 SHALL index BTB with pc[log2(BTB_ENTRIES)+1:2], tag pc[31:log2(BTB_ENTRIES)+2]; hit = valid AND tag equal.
REQ-018 SHALL assert o_IF_pred_taken combinationally iff BTB hit AND PHT counter MSB = 1.
REQ-019 SHALL drive o_IF_pc_target = BTB target when o_IF_pred_taken, else i_IF_pc+4, unless REQ-021 overrides; o_IF_ghr = current GHR.
REQ-020 SHALL assert o_branch_flush combinationally iff i_EX_valid AND (i_EX_pred_taken != i_EX_pc_sel OR (both 1 AND i_EX_pred_target != i_EX_alu_data)); 0 when i_EX_valid = 0.
REQ-021 SHALL, during flush, drive o_IF_pc_target = i_EX_alu_data if i_EX_pc_sel else i_EX_pc+4 (EX priority).
REQ-022 SHALL on each edge with i_EX_valid update PHT[EX index]: saturating +1 if taken, -1 if not; no wrap at 0 or 2^CTR_BITS-1.
REQ-023 SHALL on each edge with i_EX_valid AND i_EX_pc_sel write BTB valid=1, tag, target=i_EX_alu_data; not-taken never invalidates.
REQ-024 SHALL update GHR speculatively: i_IF_valid AND BTB hit AND no flush -> GHR <= {GHR[GHR_BITS-2:0], o_IF_pred_taken}.
REQ-025 SHALL repair on flush: GHR <= {i_EX_ghr[GHR_BITS-2:0], i_EX_pc_sel}; flush beats REQ-024 same cycle. GHR_BITS=1 -> GHR <= outcome bit.
REQ-026 SHALL read old table contents when IF and EX touch same entry same cycle (read-before-write).
REQ-027 SHALL increment o_perf_branches per i_EX_valid edge and o_perf_mispred per flush edge; both wrap at 2^32.
REQ-028 SHALL hold GHR and tables when i_IF_valid = 0 and i_EX_valid = 0.

Reset
REQ-029 SHALL on i_reset low, immediately: all PHT counters = 2^(CTR_BITS-1)-1 (weakly not taken), all BTB valid = 0, GHR = 0, perf counters = 0; reset mid-operation discards speculative history.
REQ-030 SHALL hold o_IF_pred_taken = 0, o_IF_pc_target = i_IF_pc+4 during reset with i_EX_valid = 0.

Verification
REQ-031 SHALL pass: after reset, i_IF_pc=0x100 -> pred_taken=0, target 0x104, o_IF_ghr=0.
REQ-032 SHALL pass: EX branch pc=0x100 taken to 0x200, pred_taken=0, ghr=0 -> flush=1, target 0x200; next cycle GHR=1, BTB[0x100] valid, perf_mispred=1.
REQ-033 SHALL pass: same branch resolved taken twice more (CTR_BITS=2) -> counter 1->2->3, no further increment; IF at 0x100 with matching GHR predicts taken, target 0x200.
REQ-034 SHALL pass: predicted taken to 0x200, actual target 0x300 -> flush=1, target 0x300, BTB target becomes 0x300.
REQ-035 SHALL pass: flush and IF BTB hit same cycle -> GHR takes repair value only; o_IF_pc_target = EX value.
REQ-036 SHALL pass: i_reset asserted mid-stream with counters saturated -> all outputs/tables return to REQ-029 values without a clock edge.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor with a direct-mapped branch target buffer.
//
// The IF side looks up the pattern history table (PHT) and the BTB
// combinationally and produces a next-fetch PC. The EX side resolves
// control-flow instructions, trains the tables, repairs the global history
// on a misprediction, and redirects fetch through the same target output.
//
// Ports
//   i_clk              clock, all state on the rising edge
//   i_reset            asynchronous, active-low reset
//   i_IF_pc            fetch PC
//   i_IF_valid         fetch advances this cycle
//   o_IF_pred_taken    fetch PC predicted taken
//   o_IF_pc_target     next fetch PC (EX redirect has priority)
//   o_IF_ghr           history snapshot used for this fetch
//   i_EX_valid         control-flow instruction resolving in EX
//   i_EX_pc            PC of the resolving instruction
//   i_EX_pc_sel        actual direction (1 = taken)
//   i_EX_alu_data      actual target
//   i_EX_pred_taken    prediction carried from IF
//   i_EX_pred_target   predicted target carried from IF
//   i_EX_ghr           history snapshot carried from IF
//   o_branch_flush     misprediction, flush IF/ID
//   o_perf_branches    resolved control-flow instruction count
//   o_perf_mispred     misprediction count
module branch_predictor_gshare #(
    parameter int unsigned BHT_ENTRIES = 1024,
    parameter int unsigned BTB_ENTRIES = 256,
    parameter int unsigned GHR_BITS    = 10,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_IF_pc,
    input  logic                i_IF_valid,
    output logic                o_IF_pred_taken,
    output logic [31:0]         o_IF_pc_target,
    output logic [GHR_BITS-1:0] o_IF_ghr,
    input  logic                i_EX_valid,
    input  logic [31:0]         i_EX_pc,
    input  logic                i_EX_pc_sel,
    input  logic [31:0]         i_EX_alu_data,
    input  logic                i_EX_pred_taken,
    input  logic [31:0]         i_EX_pred_target,
    input  logic [GHR_BITS-1:0] i_EX_ghr,
    output logic                o_branch_flush,
    output logic [31:0]         o_perf_branches,
    output logic [31:0]         o_perf_mispred
);

    localparam int unsigned BHT_IDX  = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_BITS = 30 - BTB_IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

    logic [CTR_BITS-1:0] pht_q        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [31:0]         btb_target_q [BTB_ENTRIES];

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         perf_branches_q, perf_mispred_q;

    logic [BHT_IDX-1:0]  if_pht_idx, ex_pht_idx;
    logic [BTB_IDX-1:0]  if_btb_idx, ex_btb_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit;
    logic                flush;
    logic [CTR_BITS-1:0] ex_ctr, ex_ctr_next;

    // Byte-offset bits of the PCs never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_IF_pc[1:0], i_EX_pc[1:0]};

    // ---------------- IF lookup ----------------
    assign if_pht_idx = i_IF_pc[BHT_IDX+1:2] ^ BHT_IDX'(ghr_q);
    assign if_btb_idx = i_IF_pc[BTB_IDX+1:2];
    assign if_tag     = i_IF_pc[31:BTB_IDX+2];
    assign if_hit     = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);

    assign o_IF_pred_taken = if_hit && pht_q[if_pht_idx][CTR_BITS-1];
    assign o_IF_ghr        = ghr_q;

    // ---------------- EX resolution ----------------
    assign ex_pht_idx = i_EX_pc[BHT_IDX+1:2] ^ BHT_IDX'(i_EX_ghr);
    assign ex_btb_idx = i_EX_pc[BTB_IDX+1:2];
    assign ex_tag     = i_EX_pc[31:BTB_IDX+2];

    assign flush = i_EX_valid &&
                   ((i_EX_pred_taken != i_EX_pc_sel) ||
                    (i_EX_pred_taken && i_EX_pc_sel && (i_EX_pred_target != i_EX_alu_data)));
    assign o_branch_flush = flush;

    // EX redirect wins over the IF prediction.
    always_comb begin
        o_IF_pc_target = i_IF_pc + 32'd4;
        if (flush) begin
            o_IF_pc_target = i_EX_pc_sel ? i_EX_alu_data : i_EX_pc + 32'd4;
        end else if (o_IF_pred_taken) begin
            o_IF_pc_target = btb_target_q[if_btb_idx];
        end
    end

    // Saturating counter update; never wraps at either end.
    always_comb begin
        ex_ctr      = pht_q[ex_pht_idx];
        ex_ctr_next = ex_ctr;
        if (i_EX_pc_sel) begin
            if (ex_ctr != CTR_MAX) ex_ctr_next = ex_ctr + 1'b1;
        end else begin
            if (ex_ctr != '0) ex_ctr_next = ex_ctr - 1'b1;
        end
    end

    // Repair from the carried snapshot beats the speculative shift. The
    // truncating cast keeps the low GHR_BITS, which also covers GHR_BITS = 1.
    always_comb begin
        ghr_d = ghr_q;
        if (flush) begin
            ghr_d = GHR_BITS'({i_EX_ghr, i_EX_pc_sel});
        end else if (i_IF_valid && if_hit) begin
            ghr_d = GHR_BITS'({ghr_q, o_IF_pred_taken});
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ghr_q           <= '0;
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
            btb_valid_q     <= '0;
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else begin
            ghr_q <= ghr_d;
            if (i_EX_valid) begin
                pht_q[ex_pht_idx] <= ex_ctr_next;
                perf_branches_q   <= perf_branches_q + 32'd1;
                if (i_EX_pc_sel) btb_valid_q[ex_btb_idx] <= 1'b1;
            end
            if (flush) perf_mispred_q <= perf_mispred_q + 32'd1;
        end
    end

    // Tag and target are qualified by the valid bit and need no reset.
    always_ff @(posedge i_clk) begin
        if (i_EX_valid && i_EX_pc_sel) begin
            btb_tag_q[ex_btb_idx]    <= ex_tag;
            btb_target_q[ex_btb_idx] <= i_EX_alu_data;
        end
    end

    assign o_perf_branches = perf_branches_q;
    assign o_perf_mispred  = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare with default parameters.
// Expected values are queued as each step is driven, then drained against
// the DUT outputs away from the clock edge.
module tb_branch_predictor_gshare;

    localparam int SIG_PRED     = 0;
    localparam int SIG_TARGET   = 1;
    localparam int SIG_GHR      = 2;
    localparam int SIG_FLUSH    = 3;
    localparam int SIG_BRANCHES = 4;
    localparam int SIG_MISPRED  = 5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_IF_pc;
    logic        i_IF_valid;
    logic        o_IF_pred_taken;
    logic [31:0] o_IF_pc_target;
    logic [9:0]  o_IF_ghr;
    logic        i_EX_valid;
    logic [31:0] i_EX_pc;
    logic        i_EX_pc_sel;
    logic [31:0] i_EX_alu_data;
    logic        i_EX_pred_taken;
    logic [31:0] i_EX_pred_target;
    logic [9:0]  i_EX_ghr;
    logic        o_branch_flush;
    logic [31:0] o_perf_branches;
    logic [31:0] o_perf_mispred;

    branch_predictor_gshare dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_IF_pc          (i_IF_pc),
        .i_IF_valid       (i_IF_valid),
        .o_IF_pred_taken  (o_IF_pred_taken),
        .o_IF_pc_target   (o_IF_pc_target),
        .o_IF_ghr         (o_IF_ghr),
        .i_EX_valid       (i_EX_valid),
        .i_EX_pc          (i_EX_pc),
        .i_EX_pc_sel      (i_EX_pc_sel),
        .i_EX_alu_data    (i_EX_alu_data),
        .i_EX_pred_taken  (i_EX_pred_taken),
        .i_EX_pred_target (i_EX_pred_target),
        .i_EX_ghr         (i_EX_ghr),
        .o_branch_flush   (o_branch_flush),
        .o_perf_branches  (o_perf_branches),
        .o_perf_mispred   (o_perf_mispred)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            SIG_PRED:     return {31'b0, o_IF_pred_taken};
            SIG_TARGET:   return o_IF_pc_target;
            SIG_GHR:      return 32'(o_IF_ghr);
            SIG_FLUSH:    return {31'b0, o_branch_flush};
            SIG_BRANCHES: return o_perf_branches;
            SIG_MISPRED:  return o_perf_mispred;
            default:      return 'x;
        endcase
    endfunction

    task automatic expect_out(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_checks++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed 0x%08h expected 0x%08h", e.name, obs, e.exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic sel,
                          input logic [31:0] alu, input logic ptaken,
                          input logic [31:0] ptarget, input logic [9:0] ghr);
        i_EX_valid       = v;
        i_EX_pc          = pc;
        i_EX_pc_sel      = sel;
        i_EX_alu_data    = alu;
        i_EX_pred_taken  = ptaken;
        i_EX_pred_target = ptarget;
        i_EX_ghr         = ghr;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset    = 1'b0;
        i_IF_pc    = 32'h100;
        i_IF_valid = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 10'd0);

        // Outputs while held in reset.
        #2;
        expect_out("rst_pred", SIG_PRED, 32'd0);
        expect_out("rst_target", SIG_TARGET, 32'h104);
        expect_out("rst_ghr", SIG_GHR, 32'd0);
        expect_out("rst_flush", SIG_FLUSH, 32'd0);
        expect_out("rst_branches", SIG_BRANCHES, 32'd0);
        expect_out("rst_mispred", SIG_MISPRED, 32'd0);
        drain();
        #1 i_reset = 1'b1;

        // Cold lookup.
        tick();
        i_IF_valid = 1'b1;
        #1;
        expect_out("cold_pred", SIG_PRED, 32'd0);
        expect_out("cold_target", SIG_TARGET, 32'h104);
        expect_out("cold_ghr", SIG_GHR, 32'd0);
        drain();
        tick();  // BTB miss: history must hold
        i_IF_valid = 1'b0;
        #1;
        expect_out("miss_hold_ghr", SIG_GHR, 32'd0);
        drain();

        // First taken branch, predicted not taken.
        set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 10'd0);
        #1;
        expect_out("first_flush", SIG_FLUSH, 32'd1);
        expect_out("first_redirect", SIG_TARGET, 32'h200);
        drain();
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 10'd0);
        #1;
        expect_out("first_ghr", SIG_GHR, 32'd1);
        expect_out("first_branches", SIG_BRANCHES, 32'd1);
        expect_out("first_mispred", SIG_MISPRED, 32'd1);
        expect_out("ghr1_weak_pred", SIG_PRED, 32'd0);
        expect_out("ghr1_weak_target", SIG_TARGET, 32'h104);
        drain();

        // Two more taken resolutions: counter 2 -> 3 -> 3.
        for (int i = 0; i < 2; i++) begin
            set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 10'd0);
            #1;
            expect_out("train_noflush", SIG_FLUSH, 32'd0);
            drain();
            tick();
        end

        // Not-taken branch mispredicted taken; repairs GHR to 0.
        set_ex(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h900, 10'd0);
        #1;
        expect_out("nt_flush", SIG_FLUSH, 32'd1);
        expect_out("nt_redirect", SIG_TARGET, 32'h504);
        drain();
        tick();
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 10'd0);
        #1;
        expect_out("repair_ghr", SIG_GHR, 32'd0);
        expect_out("train_branches", SIG_BRANCHES, 32'd4);
        expect_out("train_mispred", SIG_MISPRED, 32'd2);
        expect_out("sat_pred", SIG_PRED, 32'd1);
        expect_out("sat_target", SIG_TARGET, 32'h200);
        drain();

        // Right direction, wrong target.
        set_ex(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 10'd0);
        #1;
        expect_out("tgt_flush", SIG_FLUSH, 32'd1);
        expect_out("tgt_redirect", SIG_TARGET, 32'h300);
        drain();
        tick();
        set_ex(1'b0, 32'h100, 1'b0, 32'h300, 1'b1, 32'h200, 10'd0);
        #1;
        expect_out("tgt_ghr", SIG_GHR, 32'd1);
        expect_out("ex_invalid_noflush", SIG_FLUSH, 32'd0);
        expect_out("ex_invalid_target", SIG_TARGET, 32'h104);
        drain();

        // Flush and IF BTB hit in the same cycle.
        i_IF_valid = 1'b1;
        set_ex(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h900, 10'd0);
        #1;
        expect_out("both_flush", SIG_FLUSH, 32'd1);
        expect_out("both_target", SIG_TARGET, 32'h504);
        drain();
        tick();
        i_IF_valid = 1'b0;
        set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 10'd0);
        #1;
        expect_out("both_ghr", SIG_GHR, 32'd0);
        expect_out("both_branches", SIG_BRANCHES, 32'd6);
        expect_out("both_mispred", SIG_MISPRED, 32'd4);
        expect_out("new_tgt_pred", SIG_PRED, 32'd1);
        expect_out("new_tgt_target", SIG_TARGET, 32'h300);
        drain();

        // Speculative history shift on a predicted-taken fetch.
        i_IF_valid = 1'b1;
        tick();
        i_IF_valid = 1'b0;
        #1;
        expect_out("spec_ghr", SIG_GHR, 32'd1);
        expect_out("spec_pred", SIG_PRED, 32'd0);
        expect_out("spec_target", SIG_TARGET, 32'h104);
        drain();
        tick();
        expect_out("idle_hold_ghr", SIG_GHR, 32'd1);
        drain();

        // Asynchronous reset mid-cycle.
        #2 i_reset = 1'b0;
        #1;
        expect_out("mid_rst_pred", SIG_PRED, 32'd0);
        expect_out("mid_rst_target", SIG_TARGET, 32'h104);
        expect_out("mid_rst_ghr", SIG_GHR, 32'd0);
        expect_out("mid_rst_branches", SIG_BRANCHES, 32'd0);
        expect_out("mid_rst_mispred", SIG_MISPRED, 32'd0);
        drain();
        #1 i_reset = 1'b1;
        i_IF_valid = 1'b1;
        tick();
        i_IF_valid = 1'b0;
        #1;
        expect_out("post_rst_pred", SIG_PRED, 32'd0);
        expect_out("post_rst_ghr", SIG_GHR, 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
